// File: rtl/fifo_arb_pkg.sv
// Shared defaults and the round-robin search used by the FIFO push arbiter.
// rr_next works on a fixed 8-wide vector; callers zero-extend and truncate.
package fifo_arb_pkg;

    localparam int unsigned NREQ_DEF      = 2;
    localparam int unsigned DATA_W_DEF    = 64;
    localparam int unsigned DEPTH_DEF     = 8;
    localparam int unsigned MAX_BURST_DEF = 4;
    localparam int unsigned MAX_REQ       = 8;

    // One-hot grant of the first valid requester at or above ptr, wrapping at nreq.
    function automatic logic [MAX_REQ-1:0] rr_next(
        input logic [2:0]         ptr,
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int unsigned        idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            idx = (32'(ptr) + i) % nreq;
            if (!found && i < nreq && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr.sv
// Combinational round-robin arbiter: one-hot grant searched upward from ptr.
// No grant is issued while stall is high.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    input  logic                    stall,
    output logic [NREQ-1:0]         grant
);
    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         ptr_ext;

    always_comb begin
        valid_ext             = '0;
        valid_ext[NREQ-1:0]   = valid;
        ptr_ext               = '0;
        ptr_ext[PTR_W-1:0]    = ptr;
        grant                 = stall ? '0 : NREQ'(rr_next(ptr_ext, valid_ext, NREQ));
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter with burst cap in front of a DEPTH-entry shift FIFO.
// Registers the FIFO shift enable/data and tracks the fill level.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = NREQ_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_W-1:0]     req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       fifo_en,
    output logic [DATA_W-1:0]          fifo_d,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       q_valid
);
    localparam int unsigned PTR_W   = $clog2(NREQ);
    localparam int unsigned FILL_W  = $clog2(DEPTH+1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST+1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [BURST_W-1:0] burst_q, burst_d, burst_inc;
    logic               fifo_en_q, fifo_en_d;
    logic [DATA_W-1:0]  fifo_d_q, fifo_d_d;
    logic [PTR_W-1:0]   grant_id_q, grant_id_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               q_valid_q, q_valid_d;

    logic               accept;
    logic               other_valid;
    logic [PTR_W-1:0]   g_idx;
    logic [DATA_W-1:0]  acc_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr_q),
        .stall (stall),
        .grant (req_ready)
    );

    always_comb begin
        g_idx    = '0;
        acc_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                g_idx    = PTR_W'(i);
                acc_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        accept      = |(req_valid & req_ready);
        other_valid = |(req_valid & ~req_ready);
    end

    // Burst count only accumulates while someone else is waiting; hitting the cap
    // hands the pointer to the next requester and clears the count.
    always_comb begin
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        burst_inc = (g_idx == grant_id_q && other_valid) ? burst_q + 1'b1 : BURST_W'(1);
        if (accept) begin
            if (burst_inc >= BURST_W'(MAX_BURST)) begin
                ptr_d   = (g_idx == PTR_W'(NREQ-1)) ? '0 : g_idx + 1'b1;
                burst_d = '0;
            end else begin
                ptr_d   = g_idx;
                burst_d = burst_inc;
            end
        end
    end

    always_comb begin
        fifo_en_d  = accept;
        fifo_d_d   = accept ? acc_data : fifo_d_q;
        grant_id_d = accept ? g_idx : grant_id_q;
        fill_d     = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (fifo_en_q && fill_q != FILL_W'(DEPTH)) begin
            fill_d = fill_q + 1'b1;
        end
        q_valid_d  = (fill_d == FILL_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            burst_q    <= '0;
            fifo_en_q  <= 1'b0;
            fifo_d_q   <= '0;
            grant_id_q <= '0;
            fill_q     <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            burst_q    <= burst_d;
            fifo_en_q  <= fifo_en_d;
            fifo_d_q   <= fifo_d_d;
            grant_id_q <= grant_id_d;
            fill_q     <= fill_d;
            q_valid_q  <= q_valid_d;
        end
    end

    assign fifo_en    = fifo_en_q;
    assign fifo_d     = fifo_d_q;
    assign grant_id   = grant_id_q;
    assign fill_level = fill_q;
    assign q_valid    = q_valid_q;

endmodule
